// File: rtl/instr_bus_router.sv
// ibr_fifo: generic synchronous FIFO exposing head entry and occupancy.
// Latency: one cycle from push to visibility at head; pop takes effect at the next edge.
// Backpressure: none internal; the caller must not push when full without a simultaneous pop.
module ibr_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_vld) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            cnt <= cnt + CNT_W'(push_vld) - CNT_W'(pop_vld);
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
endmodule

// instr_bus_router: in-order fetch router to NUM_TGT base/mask targets; IBR_FETCH_CNT_EN adds fetch counters.
// Latency: zero added on grant and response; unmapped fetches answer with an error one cycle after grant.
// Backpressure: core gnt follows the selected target gnt, withheld at MAX_OUTSTANDING or until a target switch drains.
module instr_bus_router #(
    parameter int NUM_TGT         = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = {32'h0000_0000, 32'h0004_0080},
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK = {32'hFFF0_0000, 32'hFFFF_FF80}
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        core_instr_req_i,
    output logic                        core_instr_gnt_o,
    output logic                        core_instr_rvalid_o,
    input  logic [ADDR_W-1:0]           core_instr_addr_i,
    output logic [DATA_W-1:0]           core_instr_rdata_o,
    output logic                        core_instr_err_o,
`ifdef IBR_FETCH_CNT_EN
    output logic [(NUM_TGT+1)*32-1:0]   tgt_fetch_cnt_o,
`endif
    output logic [NUM_TGT-1:0]          tgt_req_o,
    input  logic [NUM_TGT-1:0]          tgt_gnt_i,
    input  logic [NUM_TGT-1:0]          tgt_rvalid_i,
    output logic [NUM_TGT*ADDR_W-1:0]   tgt_addr_o,
    input  logic [NUM_TGT*DATA_W-1:0]   tgt_rdata_i,
    input  logic [NUM_TGT-1:0]          tgt_err_i
);
    localparam int SEL_W = $clog2(NUM_TGT + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SEL_W-1:0] UNMAPPED = SEL_W'(NUM_TGT);

    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  head_id;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unm_pend;
    logic              head_rvalid;
    logic [DATA_W-1:0] head_rdata;
    logic              head_err;
    logic              pop;
    logic              can_issue;
    logic              issue;
    logic              gnt;

    // Lowest-index hit wins when windows overlap.
    always_comb begin
        sel = UNMAPPED;
        for (int k = NUM_TGT - 1; k >= 0; k--) begin
            if ((core_instr_addr_i & TGT_MASK[k*ADDR_W +: ADDR_W]) == TGT_BASE[k*ADDR_W +: ADDR_W]) begin
                sel = SEL_W'(k);
            end
        end
    end

    always_comb begin
        head_rvalid = 1'b0;
        head_rdata  = '0;
        head_err    = 1'b0;
        if (head_id == UNMAPPED) begin
            head_rvalid = unm_pend;
            head_err    = 1'b1;
        end else begin
            for (int k = 0; k < NUM_TGT; k++) begin
                if (head_id == SEL_W'(k)) begin
                    head_rvalid = tgt_rvalid_i[k];
                    head_rdata  = tgt_rdata_i[k*DATA_W +: DATA_W];
                    head_err    = tgt_err_i[k];
                end
            end
        end
    end

    // Responses from anything other than the oldest fetch's target are ignored.
    assign pop       = head_rvalid & ~fifo_empty & ~rst_i;
    assign can_issue = (~fifo_full | pop)
                     & (fifo_empty | (sel == head_id) | ((fifo_cnt == CNT_W'(1)) & pop));
    assign issue     = core_instr_req_i & can_issue & ~rst_i;

    always_comb begin
        tgt_req_o = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            tgt_req_o[k] = issue & (sel == SEL_W'(k));
        end
    end

    assign gnt                 = (sel == UNMAPPED) ? issue : |(tgt_gnt_i & tgt_req_o);
    assign core_instr_gnt_o    = gnt;
    assign core_instr_rvalid_o = pop;
    assign core_instr_rdata_o  = pop ? head_rdata : '0;
    assign core_instr_err_o    = pop & head_err;
    assign tgt_addr_o          = rst_i ? '0 : {NUM_TGT{core_instr_addr_i}};

    ibr_fifo #(
        .W     (SEL_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (gnt),
        .push_dat (sel),
        .pop_vld  (pop),
        .head_dat (head_id),
        .cnt      (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            unm_pend <= 1'b0;
        end else begin
            unm_pend <= gnt & (sel == UNMAPPED);
        end
    end

`ifdef IBR_FETCH_CNT_EN
    logic [31:0] fetch_cnt [NUM_TGT+1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_TGT; k++) begin
                fetch_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k <= NUM_TGT; k++) begin
                if (gnt && (sel == SEL_W'(k))) begin
                    fetch_cnt[k] <= fetch_cnt[k] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g <= NUM_TGT; g++) begin : g_cnt_out
        assign tgt_fetch_cnt_o[g*32 +: 32] = fetch_cnt[g];
    end
`endif
endmodule

// File: tb/tb_instr_bus_router.sv
// Directed bench for instr_bus_router: queue-based reference model checked every cycle plus literal expectations.
module tb_instr_bus_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  tgt_req;
    logic [1:0]  tgt_gnt = '0;
    logic [1:0]  tgt_rvalid = '0;
    logic [63:0] tgt_addr;
    logic [63:0] tgt_rdata = '0;
    logic [1:0]  tgt_err = '0;
`ifdef IBR_FETCH_CNT_EN
    logic [95:0] fetch_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_bus_router dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .core_instr_req_i    (req),
        .core_instr_gnt_o    (gnt),
        .core_instr_rvalid_o (rvalid),
        .core_instr_addr_i   (addr),
        .core_instr_rdata_o  (rdata),
        .core_instr_err_o    (err),
`ifdef IBR_FETCH_CNT_EN
        .tgt_fetch_cnt_o     (fetch_cnt),
`endif
        .tgt_req_o           (tgt_req),
        .tgt_gnt_i           (tgt_gnt),
        .tgt_rvalid_i        (tgt_rvalid),
        .tgt_addr_o          (tgt_addr),
        .tgt_rdata_i         (tgt_rdata),
        .tgt_err_i           (tgt_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: address windows, in-order queue of outstanding fetches.
    typedef struct {
        int tgt;
        int gcyc;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    logic [31:0] base [2] = '{32'h0004_0080, 32'h0000_0000};
    logic [31:0] mask [2] = '{32'hFFFF_FF80, 32'hFFF0_0000};

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < 2; k++) begin
            if ((a & mask[k]) == base[k]) return k;
        end
        return 2;
    endfunction

    always @(negedge clk) begin
        int          s;
        int          occ;
        bit          rv;
        bit          ok;
        logic [1:0]  e_req;
        bit          e_gnt;
        logic [31:0] e_rdata;
        bit          e_err;
        if (rst) begin
            chk("m_rst_req", tgt_req, 0);
            chk("m_rst_gnt", gnt, 0);
            chk("m_rst_rvalid", rvalid, 0);
            chk("m_rst_addr", tgt_addr, 0);
            q.delete();
        end else begin
            s       = decode(addr);
            rv      = 0;
            e_rdata = 0;
            e_err   = 0;
            if (q.size() > 0) begin
                if (q[0].tgt == 2) begin
                    rv    = (q[0].gcyc == cyc - 1);
                    e_err = rv;
                end else begin
                    rv      = tgt_rvalid[q[0].tgt];
                    e_rdata = rv ? tgt_rdata[q[0].tgt*32 +: 32] : 32'h0;
                    e_err   = rv & tgt_err[q[0].tgt];
                end
            end
            occ = q.size() - int'(rv);
            ok  = (occ < 2);
            for (int i = int'(rv); i < q.size(); i++) begin
                if (q[i].tgt != s) ok = 0;
            end
            e_req = (req && ok && s < 2) ? 2'(1 << s) : 2'b00;
            e_gnt = req && ok && (s == 2 || tgt_gnt[s]);
            chk("m_tgt_req", tgt_req, e_req);
            chk("m_gnt", gnt, e_gnt);
            chk("m_rvalid", rvalid, rv);
            chk("m_rdata", rdata, e_rdata);
            chk("m_err", err, e_err);
            chk("m_addr", tgt_addr, {addr, addr});
            if (rv) void'(q.pop_front());
            if (e_gnt) q.push_back('{s, cyc});
        end
        cyc++;
    end

    task automatic drive(input logic rs, input logic r, input logic [31:0] a, input logic [1:0] g,
                         input logic [1:0] rv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] e);
        @(posedge clk);
        #1;
        rst        = rs;
        req        = r;
        addr       = a;
        tgt_gnt    = g;
        tgt_rvalid = rv;
        tgt_rdata  = {d1, d0};
        tgt_err    = e;
        @(negedge clk);
    endtask

    initial begin
        // Reset with a live request: everything must stay quiet.
        drive(1, 1, 32'h0004_0080, 2'b11, 2'b11, 32'h1, 32'h2, 2'b11);
        chk("rst_tgt_req", tgt_req, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // 1: mapped to target 0
        drive(0, 1, 32'h0004_0080, 2'b01, 2'b00, 0, 0, 0);
        chk("t1_tgt_req", tgt_req, 2'b01);
        chk("t1_gnt", gnt, 1);
        chk("t1_addr", tgt_addr[31:0], 32'h0004_0080);
        drive(0, 0, 0, 0, 2'b01, 32'h0000_0013, 0, 0);
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata, 32'h0000_0013);
        chk("t1_err", err, 0);

        // 2: mapped to target 1 with error
        drive(0, 1, 32'h0000_1000, 2'b10, 2'b00, 0, 0, 0);
        chk("t2_tgt_req", tgt_req, 2'b10);
        chk("t2_gnt", gnt, 1);
        drive(0, 0, 0, 0, 2'b10, 0, 32'h0000_DEAD, 2'b10);
        chk("t2_rvalid", rvalid, 1);
        chk("t2_err", err, 1);
        chk("t2_rdata", rdata, 32'h0000_DEAD);

        // 3: unmapped
        drive(0, 1, 32'h8000_0000, 2'b00, 2'b00, 0, 0, 0);
        chk("t3_tgt_req", tgt_req, 0);
        chk("t3_gnt", gnt, 1);
        chk("t3_rvalid_same", rvalid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_rvalid", rvalid, 1);
        chk("t3_err", err, 1);
        chk("t3_rdata", rdata, 0);
`ifdef IBR_FETCH_CNT_EN
        chk("cnt_t0", fetch_cnt[31:0], 1);
        chk("cnt_t1", fetch_cnt[63:32], 1);
        chk("cnt_unm", fetch_cnt[95:64], 1);
`endif

        // 4: target switch waits for drain, issues on the pop cycle
        drive(0, 1, 32'h0004_0080, 2'b01, 0, 0, 0, 0);
        chk("t4_gnt0", gnt, 1);
        drive(0, 1, 32'h0000_1000, 2'b10, 0, 0, 0, 0);
        chk("t4_hold_req", tgt_req, 0);
        chk("t4_hold_gnt", gnt, 0);
        drive(0, 1, 32'h0000_1000, 2'b10, 0, 0, 0, 0);
        chk("t4_hold_gnt2", gnt, 0);
        drive(0, 1, 32'h0000_1000, 2'b10, 2'b01, 32'h55, 0, 0);
        chk("t4_pop_rvalid", rvalid, 1);
        chk("t4_pop_req", tgt_req, 2'b10);
        chk("t4_pop_gnt", gnt, 1);
        drive(0, 0, 0, 0, 2'b10, 0, 32'h77, 0);
        chk("t4_rdata1", rdata, 32'h77);

        // 5: outstanding limit; non-head rvalid dropped
        drive(0, 1, 32'h0004_0080, 2'b01, 0, 0, 0, 0);
        chk("t5_gnt_a", gnt, 1);
        drive(0, 1, 32'h0004_0084, 2'b01, 0, 0, 0, 0);
        chk("t5_gnt_b", gnt, 1);
        drive(0, 1, 32'h0004_0088, 2'b01, 2'b10, 0, 32'hBAD, 0);
        chk("t5_full_gnt", gnt, 0);
        chk("t5_nonhead_rvalid", rvalid, 0);
        drive(0, 1, 32'h0004_0088, 2'b01, 0, 0, 0, 0);
        chk("t5_full_gnt2", gnt, 0);
        drive(0, 1, 32'h0004_0088, 2'b01, 2'b01, 32'hA1, 0, 0);
        chk("t5_pop_gnt", gnt, 1);
        chk("t5_rdata_a", rdata, 32'hA1);
        drive(0, 0, 0, 0, 2'b01, 32'hA2, 0, 0);
        chk("t5_rdata_b", rdata, 32'hA2);
        drive(0, 0, 0, 0, 2'b01, 32'hA3, 0, 0);
        chk("t5_rdata_c", rdata, 32'hA3);

        // 6: reset mid-flight, late rvalids dropped
        drive(0, 1, 32'h0004_0080, 2'b01, 0, 0, 0, 0);
        drive(0, 1, 32'h0004_0084, 2'b01, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b01, 32'h11, 0, 0);
        chk("t6_late_rvalid", rvalid, 0);
        drive(0, 0, 0, 0, 2'b01, 32'h12, 0, 0);
        chk("t6_late_rvalid2", rvalid, 0);
        drive(0, 1, 32'h0000_1000, 2'b10, 0, 0, 0, 0);
        chk("t6_gnt", gnt, 1);
        drive(0, 0, 0, 0, 2'b10, 0, 32'h99, 0);
        chk("t6_rvalid", rvalid, 1);
        chk("t6_rdata", rdata, 32'h99);

        // Back-to-back unmapped fetches
        drive(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
        chk("u_gnt_a", gnt, 1);
        drive(0, 1, 32'h8000_0004, 0, 0, 0, 0, 0);
        chk("u_gnt_b", gnt, 1);
        chk("u_rvalid_a", rvalid, 1);
        chk("u_err_a", err, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("u_rvalid_b", rvalid, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("u_idle", rvalid, 0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
